// File: rtl/gol_row_sequencer.sv
// Game of Life generation sequencer: strobes the row decoder through every row, one row per clock.
// Starts from a period timer (run_en) or a single step request; one pending request is queued while busy.
module gol_row_sequencer #(
  parameter int ROWS        = 8,
  parameter int TICK_CYCLES = 1000,
  parameter int GEN_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run_en,
  input  logic                    step_req,
  output logic                    dec_ena,
  output logic [$clog2(ROWS)-1:0] dec_addr,
  output logic                    busy,
  output logic                    gen_done,
  output logic [GEN_W-1:0]        gen_count
);

  localparam int AW = $clog2(ROWS);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_ROW  = AW'(ROWS - 1);
  localparam logic [PW-1:0] LAST_TICK = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_row;
  logic [PW-1:0]    r_presc;
  logic             r_pending;
  logic             r_dec_ena;
  logic [AW-1:0]    r_dec_addr;
  logic             r_busy;
  logic             r_gen_done;
  logic [GEN_W-1:0] r_gen_count;

  logic w_tick;
  logic w_req;
  logic w_start;

  assign w_tick  = run_en && (r_presc == LAST_TICK);
  assign w_req   = w_tick || step_req;
  assign w_start = w_req || r_pending;

  // Prescaler parks at 0 while stopped so a re-enable waits a full period.
  always_ff @(posedge clk) begin
    if (rst || !run_en || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_pending   <= 1'b0;
      r_dec_ena   <= 1'b0;
      r_dec_addr  <= '0;
      r_busy      <= 1'b0;
      r_gen_done  <= 1'b0;
      r_gen_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_gen_done <= 1'b0;
          if (w_start) begin
            r_state    <= SCAN;
            r_row      <= '0;
            r_pending  <= 1'b0;
            r_dec_ena  <= 1'b1;
            r_dec_addr <= '0;
            r_busy     <= 1'b1;
          end
        end
        SCAN: begin
          if (w_req) r_pending <= 1'b1;
          if (r_row == LAST_ROW) begin
            r_state     <= DONE;
            r_dec_ena   <= 1'b0;
            r_dec_addr  <= '0;
            r_gen_done  <= 1'b1;
            r_gen_count <= r_gen_count + 1'b1;
          end else begin
            r_row      <= r_row + 1'b1;
            r_dec_addr <= r_row + 1'b1;
          end
        end
        DONE: begin
          if (w_req) r_pending <= 1'b1;
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_gen_done <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_dec_ena  <= 1'b0;
          r_dec_addr <= '0;
          r_busy     <= 1'b0;
          r_gen_done <= 1'b0;
        end
      endcase
    end
  end

  assign dec_ena   = r_dec_ena;
  assign dec_addr  = r_dec_addr;
  assign busy      = r_busy;
  assign gen_done  = r_gen_done;
  assign gen_count = r_gen_count;

endmodule

// File: tb/tb_gol_row_sequencer.sv
// Bench for gol_row_sequencer: two instances (ROWS=4/GEN_W=16 and ROWS=5/GEN_W=2) share stimulus and
// are compared every cycle against a start-time based reference model, plus directed end-of-phase counts.
module tb_gol_row_sequencer;

  localparam int RA = 4, TA = 10, GA = 16;
  localparam int RB = 5, TB = 12, GB = 2;

  logic clk = 1'b0;
  logic rst, run_en, step_req;

  logic          ena_a, busy_a, done_a;
  logic [1:0]    addr_a;
  logic [GA-1:0] cnt_a;
  logic          ena_b, busy_b, done_b;
  logic [2:0]    addr_b;
  logic [GB-1:0] cnt_b;

  gol_row_sequencer #(.ROWS(RA), .TICK_CYCLES(TA), .GEN_W(GA)) u_a (
    .clk(clk), .rst(rst), .run_en(run_en), .step_req(step_req),
    .dec_ena(ena_a), .dec_addr(addr_a), .busy(busy_a), .gen_done(done_a), .gen_count(cnt_a)
  );

  gol_row_sequencer #(.ROWS(RB), .TICK_CYCLES(TB), .GEN_W(GB)) u_b (
    .clk(clk), .rst(rst), .run_en(run_en), .step_req(step_req),
    .dec_ena(ena_b), .dec_addr(addr_b), .busy(busy_b), .gen_done(done_b), .gen_count(cnt_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a generation is described only by the edge s that accepted it; the
  // interval after edge e has offset d=e-s+1 (rows on d=1..ROWS, done on d=ROWS+1).
  int m_rows[2] = '{RA, RB};
  int m_tick[2] = '{TA, TB};
  int m_mask[2] = '{(1 << GA) - 1, (1 << GB) - 1};
  int presc[2]  = '{0, 0};
  int s[2]      = '{0, 0};
  int cnt[2]    = '{0, 0};
  bit act[2]    = '{0, 0};
  bit pend[2]   = '{0, 0};
  bit x_ena[2], x_busy[2], x_done[2];
  int x_addr[2];
  int e = 0;
  bit chk_on = 0;

  always @(posedge clk) begin
    bit tick, busy_cur;
    int dnew;
    for (int i = 0; i < 2; i++) begin
      tick     = run_en && (presc[i] == m_tick[i] - 1);
      busy_cur = act[i] && (e - s[i] >= 1) && (e - s[i] <= m_rows[i] + 1);
      if (rst) begin
        presc[i] = 0; act[i] = 0; pend[i] = 0; cnt[i] = 0;
      end else begin
        if (busy_cur) begin
          if (tick || step_req) pend[i] = 1;
        end else if (tick || step_req || pend[i]) begin
          act[i] = 1; s[i] = e; pend[i] = 0;
        end
        presc[i] = (run_en && !tick) ? presc[i] + 1 : 0;
        if (act[i] && (e - s[i] + 1 == m_rows[i] + 1)) cnt[i] = (cnt[i] + 1) & m_mask[i];
      end
      dnew      = e - s[i] + 1;
      x_ena[i]  = act[i] && dnew >= 1 && dnew <= m_rows[i];
      x_addr[i] = x_ena[i] ? dnew - 1 : 0;
      x_busy[i] = act[i] && dnew >= 1 && dnew <= m_rows[i] + 1;
      x_done[i] = act[i] && dnew == m_rows[i] + 1;
    end
    if (rst) chk_on = 1;
    e++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_ena",  int'(ena_a),  int'(x_ena[0]));
      chk("a_addr", int'(addr_a), x_addr[0]);
      chk("a_busy", int'(busy_a), int'(x_busy[0]));
      chk("a_done", int'(done_a), int'(x_done[0]));
      chk("a_cnt",  int'(cnt_a),  cnt[0]);
      chk("b_ena",  int'(ena_b),  int'(x_ena[1]));
      chk("b_addr", int'(addr_b), x_addr[1]);
      chk("b_busy", int'(busy_b), int'(x_busy[1]));
      chk("b_done", int'(done_b), int'(x_done[1]));
      chk("b_cnt",  int'(cnt_b),  cnt[1]);
      chk("b_addr_range", int'(addr_b <= 3'(RB - 1)), 1);
    end
  end

  task automatic drive(input bit r, input bit re, input bit st);
    rst = r; run_en = re; step_req = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit re;
    rst = 1'b1; run_en = 1'b0; step_req = 1'b0;

    // Single step from reset
    drive(1, 0, 0); drive(1, 0, 0);
    drive(0, 0, 1);
    repeat (12) drive(0, 0, 0);
    chk("step_cnt_a", int'(cnt_a), 1);
    chk("step_cnt_b", int'(cnt_b), 1);

    // Free running for 35 cycles
    drive(1, 0, 0);
    repeat (10) drive(0, 1, 0);
    chk("run_early_a", int'(cnt_a), 0);
    repeat (25) drive(0, 1, 0);
    repeat (20) drive(0, 0, 0);
    chk("run_cnt_a", int'(cnt_a), 3);
    chk("run_cnt_b", int'(cnt_b), 2);

    // Step in SCAN row 1, then again in DONE: one queued generation
    drive(1, 0, 0);
    drive(0, 0, 1); drive(0, 0, 0); drive(0, 0, 1);
    drive(0, 0, 0); drive(0, 0, 0); drive(0, 0, 1);
    repeat (25) drive(0, 0, 0);
    chk("pend_cnt_a", int'(cnt_a), 2);

    // Step coincident with tick
    drive(1, 0, 0);
    repeat (9) drive(0, 1, 0);
    drive(0, 1, 1);
    repeat (15) drive(0, 0, 0);
    chk("coinc_cnt_a", int'(cnt_a), 1);
    chk("coinc_cnt_b", int'(cnt_b), 1);

    // Reset mid-scan
    drive(1, 0, 0);
    drive(0, 0, 1);
    n = 0;
    while (addr_a != 2'd2 && n < 10) begin
      drive(0, 0, 0);
      n++;
    end
    if (n >= 10) chk("wait_row2_timeout", 0, 1);
    drive(1, 0, 0);
    chk("rst_ena_a",  int'(ena_a),  0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_cnt_a",  int'(cnt_a),  0);
    drive(0, 0, 1);
    repeat (10) drive(0, 0, 0);
    chk("rst_rescan_cnt_a", int'(cnt_a), 1);

    // Five steps: GEN_W=2 instance wraps
    drive(1, 0, 0);
    repeat (5) begin
      drive(0, 0, 1);
      repeat (9) drive(0, 0, 0);
    end
    chk("wrap_cnt_b", int'(cnt_b), 1);
    chk("five_cnt_a", int'(cnt_a), 5);

    // Randomized run/step/reset traffic
    drive(1, 0, 0);
    re = 1'b0;
    repeat (3000) begin
      if ($urandom_range(63) == 0) re = ~re;
      drive($urandom_range(299) == 0, re, $urandom_range(5) == 0);
    end
    repeat (20) drive(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
